// File: rtl/block_mem_ctrl.sv
// Multi-element block memory: BLOCK_SIZE-wide writes/reads with modulo-DEPTH wrap,
// registered read with write-first forwarding, and a block-at-a-time clear FSM.
module block_mem_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int SIZE       = 32,
  parameter int BLOCK_SIZE = 5,
  parameter int ADDR_SIZE  = 24
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_wr_en,
  input  logic [ADDR_SIZE-1:0]               i_addr_w,
  input  logic [$clog2(BLOCK_SIZE+1)-1:0]    i_wr_size,
  input  logic [SIZE*BLOCK_SIZE-1:0]         i_data_w,
  input  logic                               i_rd_req,
  input  logic [ADDR_SIZE-1:0]               i_addr_r,
  output logic [SIZE*BLOCK_SIZE-1:0]         o_rd_data,
  output logic                               o_rd_valid,
  output logic                               o_rd_ready,
  input  logic                               i_clr,
  output logic                               o_busy,
  output logic                               o_addr_err,
  output logic                               o_dbg_state
);

  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WSW = $clog2(BLOCK_SIZE+1);
  localparam logic [ADDR_SIZE:0] DEPTH_X = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] BS_X    = (ADDR_SIZE+1)'(BLOCK_SIZE);
  localparam logic [WSW-1:0]     BS_W    = WSW'(BLOCK_SIZE);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDR_SIZE:0]        r_ptr, w_ptr_nxt;
  logic [SIZE-1:0]           r_mem [DEPTH];
  logic [SIZE*BLOCK_SIZE-1:0] r_rd_data, w_rd_nxt;
  logic                      r_rd_valid, r_addr_err;

  logic [AIW-1:0]            w_widx [BLOCK_SIZE];
  logic [AIW-1:0]            w_ridx [BLOCK_SIZE];
  logic [AIW-1:0]            w_cidx [BLOCK_SIZE];
  logic [BLOCK_SIZE-1:0]     w_wmask, w_cmask;
  logic                      w_idle, w_wr_acc, w_rd_acc, w_wok, w_rok;
  logic [WSW-1:0]            w_wsize;

  // Base is only meaningful when < DEPTH; then base+k < 2*DEPTH, so one subtract wraps it.
  function automatic logic [AIW-1:0] wrap_idx(input logic [ADDR_SIZE-1:0] base, input int k);
    logic [ADDR_SIZE:0] s;
    s = {1'b0, base} + (ADDR_SIZE+1)'(k);
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return AIW'(s);
  endfunction

  // Handshake: a read is accepted on a rising edge where i_rd_req && o_rd_ready (and no i_clr);
  // o_rd_valid pulses for exactly one cycle after each accepted read, with no back-pressure.
  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_acc = w_idle && !i_clr && i_wr_en;
  assign w_rd_acc = w_idle && !i_clr && i_rd_req;
  assign w_wok    = ({1'b0, i_addr_w} < DEPTH_X);
  assign w_rok    = ({1'b0, i_addr_r} < DEPTH_X);
  assign w_wsize  = (i_wr_size > BS_W) ? BS_W : i_wr_size;

  always_comb begin
    w_widx   = '{default: '0};
    w_ridx   = '{default: '0};
    w_cidx   = '{default: '0};
    w_wmask  = '0;
    w_cmask  = '0;
    w_rd_nxt = '0;
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      w_widx[k]  = wrap_idx(i_addr_w, k);
      w_ridx[k]  = wrap_idx(i_addr_r, k);
      w_wmask[k] = w_wr_acc && w_wok && (WSW'(k) < w_wsize);
      w_cidx[k]  = AIW'(r_ptr + (ADDR_SIZE+1)'(k));
      w_cmask[k] = (r_state == S_CLEAR) && ((r_ptr + (ADDR_SIZE+1)'(k)) < DEPTH_X);
    end
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      w_rd_nxt[(BLOCK_SIZE-k)*SIZE-1 -: SIZE] = r_mem[w_ridx[k]];
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        if (w_wmask[j] && (w_widx[j] == w_ridx[k]))
          w_rd_nxt[(BLOCK_SIZE-k)*SIZE-1 -: SIZE] = i_data_w[(BLOCK_SIZE-j)*SIZE-1 -: SIZE];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (i_clr) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if ((r_ptr + BS_X) >= DEPTH_X) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt   = r_ptr + BS_X;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rd_valid <= w_rd_acc;
      r_addr_err <= (w_wr_acc && !w_wok) || (w_rd_acc && !w_rok);
      if (w_rd_acc) r_rd_data <= w_rok ? w_rd_nxt : '0;
    end
  end

  // Storage has no reset; clear zeroing and normal writes never coincide.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
      if (w_cmask[k])
        r_mem[w_cidx[k]] <= '0;
      else if (w_wmask[k])
        r_mem[w_widx[k]] <= i_data_w[(BLOCK_SIZE-k)*SIZE-1 -: SIZE];
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_busy      = (r_state == S_CLEAR);
  assign o_rd_ready  = ~o_busy;
  assign o_addr_err  = r_addr_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Directed bench for block_mem_ctrl (DEPTH=16, SIZE=8, BLOCK_SIZE=4) with a read-data
// scoreboard: reads push expected blocks, a negedge monitor pops on every o_rd_valid.
module tb_block_mem_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [7:0]  i_addr_w = '0;
  logic [2:0]  i_wr_size = '0;
  logic [31:0] i_data_w = '0;
  logic        i_rd_req = 1'b0;
  logic [7:0]  i_addr_r = '0;
  logic [31:0] o_rd_data;
  logic        o_rd_valid, o_rd_ready, o_busy, o_addr_err, o_dbg_state;
  logic        i_clr = 1'b0;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  block_mem_ctrl #(.DEPTH(16), .SIZE(8), .BLOCK_SIZE(4), .ADDR_SIZE(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_addr_w(i_addr_w),
    .i_wr_size(i_wr_size), .i_data_w(i_data_w), .i_rd_req(i_rd_req), .i_addr_r(i_addr_r),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_ready(o_rd_ready),
    .i_clr(i_clr), .o_busy(o_busy), .o_addr_err(o_addr_err), .o_dbg_state(o_dbg_state)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [2:0] n, input logic [31:0] d);
    i_wr_en = 1'b1; i_addr_w = a; i_wr_size = n; i_data_w = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    i_rd_req = 1'b1; i_addr_r = a;
    tick();
    i_rd_req = 1'b0;
  endtask

  // Pulses i_clr with a read request held for the whole clear; returns the busy cycle count.
  task automatic run_clear(output int n);
    n = 0;
    i_clr = 1'b1; i_rd_req = 1'b1; i_addr_r = 8'd0;
    tick();
    i_clr = 1'b0;
    chk("busy_rise", {31'd0, o_busy}, 32'd1);
    chk("ready_low_busy", {31'd0, o_rd_ready}, 32'd0);
    repeat (20) begin
      @(negedge i_clk);
      if (o_busy) n++;
      else break;
    end
    i_rd_req = 1'b0;
    tick();
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (i_rst_n && o_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got data %h with no read outstanding", o_rd_data);
      end else begin
        chk("rd_data", o_rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_rd_data", o_rd_data, 32'h0);
    chk("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ready", {31'd0, o_rd_ready}, 32'd1);
    chk("rst_addr_err", {31'd0, o_addr_err}, 32'd0);
    chk("rst_state", {31'd0, o_dbg_state}, 32'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    tick();

    for (int a = 0; a < 16; a += 4) wr(8'(a), 3'd4, 32'hAAAAAAAA);

    wr(8'd2, 3'd4, 32'h11223344);
    rd(8'd2, 32'h11223344);
    chk("addr_err_ok", {31'd0, o_addr_err}, 32'd0);

    wr(8'd14, 3'd3, 32'h01020304);
    rd(8'd14, 32'h010203AA);
    rd(8'd0, 32'h03AA1122);

    wr(8'd5, 3'd1, 32'h77000000);
    rd(8'd4, 32'h3377AAAA);

    // same-cycle write and read: forwarded lanes only
    exp_q.push_back(32'h3399AAAA);
    i_wr_en = 1'b1; i_addr_w = 8'd5; i_wr_size = 3'd1; i_data_w = 32'h99123456;
    i_rd_req = 1'b1; i_addr_r = 8'd4;
    tick();
    i_wr_en = 1'b0; i_rd_req = 1'b0;
    rd(8'd4, 32'h3399AAAA);

    exp_q.push_back(32'h015566AA);
    i_wr_en = 1'b1; i_addr_w = 8'd15; i_wr_size = 3'd2; i_data_w = 32'h55660000;
    i_rd_req = 1'b1; i_addr_r = 8'd14;
    tick();
    i_wr_en = 1'b0; i_rd_req = 1'b0;

    wr(8'd8, 3'd7, 32'hDEADBEEF);
    rd(8'd8, 32'hDEADBEEF);
    wr(8'd8, 3'd0, 32'h12345678);
    rd(8'd8, 32'hDEADBEEF);

    rd(8'd16, 32'h0);
    chk("addr_err_rd", {31'd0, o_addr_err}, 32'd1);
    wr(8'd20, 3'd4, 32'h55555555);
    chk("addr_err_wr", {31'd0, o_addr_err}, 32'd1);
    rd(8'd0, 32'h66AA1122);
    rd(8'd4, 32'h3399AAAA);

    // i_clr wins over a same-cycle read: no valid may follow
    i_clr = 1'b1; i_rd_req = 1'b1; i_addr_r = 8'd8;
    tick();
    i_clr = 1'b0; i_rd_req = 1'b0;
    repeat (6) tick();

    run_clear(n);
    chk("clear_cycles", n, 32'd4);
    for (int a = 0; a < 16; a += 4) rd(8'(a), 32'h0);

    // reset during a clear leaves later words untouched
    wr(8'd12, 3'd4, 32'hCAFEBABE);
    wr(8'd4, 3'd4, 32'h01020304);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    tick();
    tick();
    #3 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, o_rd_valid}, 32'd0);
    chk("rst_mid_state", {31'd0, o_dbg_state}, 32'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    tick();
    chk("ready_after_rst", {31'd0, o_rd_ready}, 32'd1);
    rd(8'd12, 32'hCAFEBABE);
    rd(8'd4, 32'h0);

    run_clear(n);
    chk("clear_cycles_after_rst", n, 32'd4);
    rd(8'd12, 32'h0);

    // pending valid cancelled by reset
    i_rd_req = 1'b1; i_addr_r = 8'd12;
    tick();
    i_rd_req = 1'b0;
    chk("valid_before_rst", {31'd0, o_rd_valid}, 32'd1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("valid_cancel", {31'd0, o_rd_valid}, 32'd0);
    chk("data_cancel", o_rd_data, 32'h0);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (3) tick();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
